// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words, writes them to
// instruction memory, and holds the core in reset until the image checksum matches.
module imem_loader #(
  parameter logic [15:0] BaseAddr = 16'h0000,
  parameter int unsigned MaxWords = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        imem_wen_o,
  output logic [15:0] imem_address_o,
  output logic [31:0] imem_write_data_o,
  output logic        cpu_rst_o,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] word_count_o
);

  localparam logic [16:0] MaxWordsW = 17'(MaxWords);

  typedef enum logic [2:0] {
    StIdle, StLenLo, StLenHi, StData, StChk, StDone, StErr
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [23:0] asm_q, asm_d;  // lanes 0..2; lane 3 goes straight to the write word
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  sum_q, sum_d;
  logic [15:0] word_count_q, word_count_d;
  logic        wen_q, wen_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rx_ready_q, rx_ready_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        accept;
  logic [15:0] len_full;

  assign accept   = rx_valid_i && rx_ready_q;
  assign len_full = {rx_data_i, len_q[7:0]};

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    asm_d        = asm_q;
    byte_idx_d   = byte_idx_q;
    sum_d        = sum_q;
    word_count_d = word_count_q;
    wen_d        = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;

    unique case (state_q)
      StIdle: state_d = StLenLo;
      StLenLo: begin
        if (accept) begin
          len_d[7:0] = rx_data_i;
          state_d    = StLenHi;
        end
      end
      StLenHi: begin
        if (accept) begin
          len_d[15:8] = rx_data_i;
          if ({1'b0, len_full} > MaxWordsW) begin
            state_d = StErr;
          end else if (len_full == 16'd0) begin
            state_d = StChk;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          sum_d = sum_q + rx_data_i;
          if (byte_idx_q == 2'd3) begin
            wen_d        = 1'b1;
            wdata_d      = {rx_data_i, asm_q};
            addr_d       = BaseAddr + {word_count_q[13:0], 2'b00};
            word_count_d = word_count_q + 16'd1;
            byte_idx_d   = 2'd0;
            if (word_count_q + 16'd1 == len_q) begin
              state_d = StChk;
            end
          end else begin
            asm_d[byte_idx_q*8 +: 8] = rx_data_i;
            byte_idx_d               = byte_idx_q + 2'd1;
          end
        end
      end
      StChk: begin
        if (accept) begin
          state_d = (rx_data_i == sum_q) ? StDone : StErr;
        end
      end
      StDone, StErr: state_d = state_q;
      default: state_d = StIdle;
    endcase

    // Status outputs are registered from the next state so they change with it.
    rx_ready_d = (state_d == StLenLo) || (state_d == StLenHi) ||
                 (state_d == StData)  || (state_d == StChk);
    cpu_rst_d  = (state_d != StDone);
    done_d     = (state_d == StDone);
    error_d    = (state_d == StErr);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      len_q        <= 16'd0;
      asm_q        <= 24'd0;
      byte_idx_q   <= 2'd0;
      sum_q        <= 8'd0;
      word_count_q <= 16'd0;
      wen_q        <= 1'b0;
      addr_q       <= BaseAddr;
      wdata_q      <= 32'd0;
      rx_ready_q   <= 1'b0;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      asm_q        <= asm_d;
      byte_idx_q   <= byte_idx_d;
      sum_q        <= sum_d;
      word_count_q <= word_count_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rx_ready_q   <= rx_ready_d;
      cpu_rst_q    <= cpu_rst_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign rx_ready_o        = rx_ready_q;
  assign imem_wen_o        = wen_q;
  assign imem_address_o    = addr_q;
  assign imem_write_data_o = wdata_q;
  assign cpu_rst_o         = cpu_rst_q;
  assign done_o            = done_q;
  assign error_o           = error_q;
  assign word_count_o      = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: two instances (base 0x0000 and 0x0100) share one
// stimulus driver; expected writes are queued at stimulus time and checked on each strobe.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        sel;  // 0 drives dut_a, 1 drives dut_b
  logic        rx_valid;
  logic [7:0]  rx_data;

  logic        a_ready, a_wen, a_cpu_rst, a_done, a_error;
  logic [15:0] a_addr, a_wc;
  logic [31:0] a_wdata;
  logic        b_ready, b_wen, b_cpu_rst, b_done, b_error;
  logic [15:0] b_addr, b_wc;
  logic [31:0] b_wdata;

  logic        cur_ready, cur_wen, cur_cpu_rst, cur_done, cur_error;
  logic [15:0] cur_addr, cur_wc;
  logic [31:0] cur_wdata;

  int          vectors = 0;
  int          miscompares = 0;
  int          wen_seen = 0;
  logic [47:0] exp_q[$];

  imem_loader #(.BaseAddr(16'h0000), .MaxWords(1024)) dut_a (
    .clk_i(clk), .rst_i(rst), .rx_valid_i(rx_valid && !sel), .rx_data_i(rx_data),
    .rx_ready_o(a_ready), .imem_wen_o(a_wen), .imem_address_o(a_addr),
    .imem_write_data_o(a_wdata), .cpu_rst_o(a_cpu_rst), .done_o(a_done),
    .error_o(a_error), .word_count_o(a_wc)
  );

  imem_loader #(.BaseAddr(16'h0100), .MaxWords(1024)) dut_b (
    .clk_i(clk), .rst_i(rst), .rx_valid_i(rx_valid && sel), .rx_data_i(rx_data),
    .rx_ready_o(b_ready), .imem_wen_o(b_wen), .imem_address_o(b_addr),
    .imem_write_data_o(b_wdata), .cpu_rst_o(b_cpu_rst), .done_o(b_done),
    .error_o(b_error), .word_count_o(b_wc)
  );

  assign cur_ready   = sel ? b_ready   : a_ready;
  assign cur_wen     = sel ? b_wen     : a_wen;
  assign cur_addr    = sel ? b_addr    : a_addr;
  assign cur_wdata   = sel ? b_wdata   : a_wdata;
  assign cur_cpu_rst = sel ? b_cpu_rst : a_cpu_rst;
  assign cur_done    = sel ? b_done    : a_done;
  assign cur_error   = sel ? b_error   : a_error;
  assign cur_wc      = sel ? b_wc      : a_wc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (cur_done && cur_error) check("done_error_exclusive", 32'd1, 32'd0);
    if (cur_wen) begin
      wen_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_wen", 32'd1, 32'd0);
      end else begin
        logic [47:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {16'd0, cur_addr}, {16'd0, e[47:32]});
        check("wr_data", cur_wdata, e[31:0]);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!cur_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("rx_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_image(input int gap, input logic [7:0] chk, input int nbytes);
    logic [7:0] img [11];
    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, 8'h00};
    img[10] = chk;
    for (int i = 0; i < nbytes; i++) begin
      send_byte(img[i]);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wen_seen = 0;
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    sel = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, a_ready}, 32'd0);
    check("rst_wen", {31'd0, a_wen}, 32'd0);
    check("rst_addr_a", {16'd0, a_addr}, 32'h0000);
    check("rst_addr_b", {16'd0, b_addr}, 32'h0100);
    check("rst_wdata", a_wdata, 32'd0);
    check("rst_cpu_rst", {31'd0, a_cpu_rst}, 32'd1);
    check("rst_done_err", {30'd0, a_done, a_error}, 32'd0);
    check("rst_wc", {16'd0, a_wc}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, a_ready}, 32'd1);

    // 2-word image, back-to-back bytes.
    exp_q.push_back({16'h0000, 32'h00500013});
    exp_q.push_back({16'h0004, 32'h00A00093});
    send_image(0, 8'h96, 11);
    check("t1_done", {31'd0, cur_done}, 32'd1);
    check("t1_cpu_rst", {31'd0, cur_cpu_rst}, 32'd0);
    check("t1_wc", {16'd0, cur_wc}, 32'd2);
    check("t1_ready", {31'd0, cur_ready}, 32'd0);
    check("t1_writes", wen_seen, 32'd2);
    check("t1_q_empty", exp_q.size(), 32'd0);

    // Same image with idle gaps.
    do_reset();
    exp_q.push_back({16'h0000, 32'h00500013});
    exp_q.push_back({16'h0004, 32'h00A00093});
    send_image(3, 8'h96, 11);
    check("t2_done", {31'd0, cur_done}, 32'd1);
    check("t2_writes", wen_seen, 32'd2);
    check("t2_wc", {16'd0, cur_wc}, 32'd2);

    // Bad checksum; trailing bytes must be ignored.
    do_reset();
    exp_q.push_back({16'h0000, 32'h00500013});
    exp_q.push_back({16'h0004, 32'h00A00093});
    send_image(0, 8'h97, 11);
    check("t3_error", {31'd0, cur_error}, 32'd1);
    check("t3_done", {31'd0, cur_done}, 32'd0);
    check("t3_cpu_rst", {31'd0, cur_cpu_rst}, 32'd1);
    check("t3_ready", {31'd0, cur_ready}, 32'd0);
    rx_valid = 1'b1;
    rx_data = 8'h55;
    repeat (4) @(negedge clk);
    rx_valid = 1'b0;
    check("t3_wc_hold", {16'd0, cur_wc}, 32'd2);
    check("t3_error_hold", {31'd0, cur_error}, 32'd1);
    check("t3_writes", wen_seen, 32'd2);

    // Length overflow: N = 1025.
    do_reset();
    send_byte(8'h01);
    send_byte(8'h04);
    check("t4_error", {31'd0, cur_error}, 32'd1);
    check("t4_ready", {31'd0, cur_ready}, 32'd0);
    repeat (3) @(negedge clk);
    check("t4_writes", wen_seen, 32'd0);

    // Empty image.
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    check("t5_done", {31'd0, cur_done}, 32'd1);
    check("t5_wc", {16'd0, cur_wc}, 32'd0);
    check("t5_writes", wen_seen, 32'd0);

    // Async reset after 5 payload bytes of a second load.
    do_reset();
    exp_q.push_back({16'h0000, 32'h00500013});
    send_image(0, 8'h96, 7);
    check("t6_mid_wc", {16'd0, cur_wc}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_ready", {31'd0, a_ready}, 32'd0);
    check("t6_rst_wc", {16'd0, a_wc}, 32'd0);
    check("t6_rst_addr", {16'd0, a_addr}, 32'h0000);
    check("t6_rst_wdata", a_wdata, 32'd0);
    check("t6_rst_cpu_rst", {31'd0, a_cpu_rst}, 32'd1);

    // Full reload on the 0x0100-based instance.
    @(negedge clk);
    sel = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    wen_seen = 0;
    exp_q.delete();
    exp_q.push_back({16'h0100, 32'h00500013});
    exp_q.push_back({16'h0104, 32'h00A00093});
    send_image(0, 8'h96, 11);
    check("t7_done", {31'd0, cur_done}, 32'd1);
    check("t7_cpu_rst", {31'd0, cur_cpu_rst}, 32'd0);
    check("t7_writes", wen_seen, 32'd2);
    check("t7_addr_last", {16'd0, cur_addr}, 32'h0104);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader upstream of instruction memory. Accepts a byte stream (from a UART receiver or testbench), assembles little-endian 32-bit words, and writes them sequentially into instruction memory. It holds the core in reset until the entire image and its checksum have been received. It releases the core only on a valid load. On a failed load it latches an error.

## Interface
- BASE_ADDR, 16'h0000: byte address written by the first word.
- MAX_WORDS, 1024: largest accepted image, in words; a larger header length is an error.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- rx_valid  in  1  rx_data holds a byte.
- rx_data  in  8  stream byte.
- rx_ready  out  1  loader can accept a byte; a byte transfers on a cycle with rx_valid && rx_ready.
- imem_wEn  out  1  one-cycle instruction-memory write strobe.
- imem_address  out  16  byte address of the word being written.
- imem_write_data  out  32  word being written.
- cpu_rst  out  1  reset to the core (fetch/regfile/data memory); high until a load succeeds.
- done  out  1  image loaded and checksum matched; sticky.
- error  out  1  length overflow or checksum mismatch; sticky.
- word_count  out  16  number of words written so far.

## Operation
- Stream format, in order:
  - LEN_LO, LEN_HI: word count N, 16 bits, little-endian.
  - 4*N payload bytes: each word is sent least-significant byte first.
  - CHK: one byte equal to the 8-bit modulo-256 sum of all payload bytes (length bytes excluded).
- States: IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR.
- IDLE → LEN_LO: unconditional, one cycle after reset release.
- LEN_LO → LEN_HI: on accept; stores the low length byte.
- LEN_HI exits on accept:
  - N > MAX_WORDS → ERR.
  - N == 0 → CHK.
  - otherwise → DATA.
- DATA:
  - Each accepted byte shifts into a 32-bit assembly register at byte lane byte_idx (0..3) and is added to the 8-bit sum.
  - byte_idx 3 accepted → word is issued, byte_idx wraps to 0, word_count increments.
  - After word N-1 is issued → CHK.
- CHK exits on accept: byte == sum → DONE; otherwise → ERR.
- DONE and ERR are terminal. They are left only through rst. rx_ready is 0 in both.
- Write address: imem_address = BASE_ADDR + 4*word_count, computed before the increment. It is 16-bit and wraps modulo 2^16 with no error. Bounding the image is the job of MAX_WORDS.
- Output state by FSM state:
  - rx_ready = 1 in LEN_LO, LEN_HI, DATA, CHK; 0 in IDLE, DONE, ERR.
  - cpu_rst = 0 only in DONE.
- Bytes arriving while rx_ready = 0 are ignored, with no state change.
- Back-to-back bytes (rx_valid held high) are accepted every cycle. A write strobe does not stall the stream.

## Timing
- Reset values: state IDLE, rx_ready 0, imem_wEn 0, imem_address BASE_ADDR, imem_write_data 0, cpu_rst 1, done 0, error 0, word_count 0, sum 0, byte_idx 0.
- rst assertion mid-load takes effect immediately, asynchronously:
  - All registers return to their reset values; any pending write strobe is dropped.
  - Memory contents already written are not cleared.
- All outputs are registered.
- rx_ready rises on the first clk edge after rst deasserts.
- Write strobe:
  - imem_wEn is high for exactly one cycle: the cycle after the 4th byte of a word is accepted.
  - imem_address and imem_write_data are valid in that same cycle.
  - word_count shows the new value from that cycle onward.
- Transitions out of CHK, on the edge after the checksum byte is accepted:
  - Match: done rises and cpu_rst falls on the same edge.
  - Mismatch: error rises; cpu_rst stays 1.
- Latency: from the first LEN_LO byte to done is 4N+3 accepted bytes plus one cycle.
- Overflow: error rises on the edge after the LEN_HI byte is accepted. Nothing is written.
- Invariants: done and error are never both 1; imem_wEn is never asserted outside DATA, or the cycle after leaving it.

## Test plan
- 2-word image at one byte per cycle: stream 02 00 | 13 00 50 00 | 93 00 A0 00 | 96 → writes 0x00500013 @ 0x0000, then 0x00A00093 @ 0x0004. done=1 and cpu_rst=0 on the edge after the 96 byte; word_count=2.
- Same image with 3 idle cycles (rx_valid=0) between every byte → identical writes and address sequence; no extra imem_wEn pulses.
- Same image with checksum byte 97 → error=1, done=0, cpu_rst stays 1, rx_ready=0; later bytes are ignored.
- Stream 01 04 (N=1025) with MAX_WORDS=1024 → error=1 the cycle after the second byte; imem_wEn never asserted.
- N=0: stream 00 00 00 → done=1, no writes. Then rst pulsed mid-way through a second 2-word load after 5 payload bytes → outputs immediately at reset values. A full reload from LEN_LO then succeeds with BASE_ADDR=16'h0100 (writes at 0x0100 and 0x0104).
